ave_pool_ctrl: RTL

Sequencer for the global average-pooling path. On a start pulse it walks a channel-major feature buffer, streams each channel's elements into the `vector_ave` datapath with correctly aligned enable and start-of-vector markers, and supplies the reciprocal fraction. It captures one averaged result per channel into the output buffer. It sits between the layer's feature buffer (1-cycle read latency) and the pooled-output buffer, and owns one `vector_ave` instance.

---
 rtl/ave_pool_pkg.sv | 24 ++
 rtl/vector_ave.sv | 68 ++++++
 rtl/ave_pool_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ave_pool_pkg.sv
// Shared state encoding, pipeline constants and default widths for the
// global average-pooling sequencer and its vector_ave datapath.
package ave_pool_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned CH_W_DEF   = 10;
    localparam int unsigned LEN_W_DEF  = 12;
    localparam int unsigned Q_DEF      = 8;

    // Multiply cycle + accumulate cycle + feature-buffer read-register cycle.
    localparam int unsigned DRAIN_LAT = 3;

    // Wide enough for 2^LEN_W products of a 16x16 multiply shifted by Q.
    localparam int unsigned ACC_W = 48;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPrime  = 3'd1,
        StStream = 3'd2,
        StDrain  = 3'd3,
        StFin    = 3'd4
    } state_e;

endpackage

// File: rtl/vector_ave.sv
// Streaming weighted-sum datapath: scales each element by a Q-format fraction
// and accumulates; an eop marker makes the next valid element restart the sum.
module vector_ave
    import ave_pool_pkg::*;
#(
    parameter int unsigned Q    = Q_DEF,
    parameter int unsigned RELU = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_din,
    input  logic        i_din_en,
    input  logic        i_din_eop,
    input  logic [15:0] i_fraction,
    output logic [15:0] o_dout
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic signed [31:0]      w_mult;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [31:0]      r_prod;
    logic                    r_prod_vld;
    logic                    r_prod_first;
    logic                    r_restart;
    logic signed [ACC_W-1:0] r_acc;
    logic [15:0]             w_dout;

    assign w_mult     = 32'($signed(i_din)) * 32'($signed(i_fraction));
    assign w_prod_ext = {{(ACC_W - 32){r_prod[31]}}, r_prod};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prod       <= '0;
            r_prod_vld   <= 1'b0;
            r_prod_first <= 1'b0;
            r_restart    <= 1'b0;
            r_acc        <= '0;
        end else begin
            r_prod       <= w_mult >>> Q;
            r_prod_vld   <= i_din_en;
            r_prod_first <= r_restart;
            if (i_din_eop) begin
                r_restart <= 1'b1;
            end else if (i_din_en) begin
                r_restart <= 1'b0;
            end
            if (r_prod_vld) begin
                r_acc <= r_prod_first ? w_prod_ext : r_acc + w_prod_ext;
            end
        end
    end

    always_comb begin
        w_dout = r_acc[15:0];
        if (RELU != 0 && r_acc[ACC_W-1]) begin
            w_dout = '0;
        end else if (r_acc > SAT_MAX) begin
            w_dout = 16'h7FFF;
        end else if (r_acc < SAT_MIN) begin
            w_dout = 16'h8000;
        end
    end

    assign o_dout = w_dout;

endmodule

// File: rtl/ave_pool_ctrl.sv
// Global average-pooling sequencer: walks a channel-major feature buffer,
// feeds vector_ave with aligned enable/eop markers and writes one result per channel.
module ave_pool_ctrl
    import ave_pool_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CH_W   = CH_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned Q      = Q_DEF,
    parameter int unsigned RELU   = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_cfg_base,
    input  logic [CH_W-1:0]   i_cfg_num_ch,
    input  logic [LEN_W-1:0]  i_cfg_map_len,
    input  logic [15:0]       i_cfg_fraction,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [15:0]       i_rd_data,
    output logic              o_wr_en,
    output logic [CH_W-1:0]   o_wr_addr,
    output logic [15:0]       o_wr_data
);

    localparam int unsigned   DW         = $clog2(DRAIN_LAT);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LAT - 1);
    localparam logic [DW-1:0] DRAIN_WR   = DW'(DRAIN_LAT - 2);

    state_e            r_state;
    logic [CH_W-1:0]   r_num_ch;
    logic [LEN_W-1:0]  r_map_len;
    logic [15:0]       r_fraction;
    logic [CH_W-1:0]   r_ch;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_idx;
    logic [DW-1:0]     r_drain_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_wr_en;
    logic [CH_W-1:0]   r_wr_addr;
    logic              r_op_en;
    logic              r_op_eop;
    logic              w_sov;
    logic [15:0]       w_op_dout;

    assign w_sov = (r_state == StPrime);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_num_ch    <= '0;
            r_map_len   <= '0;
            r_fraction  <= '0;
            r_ch        <= '0;
            r_addr      <= '0;
            r_idx       <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    // busy stays up through the done cycle, so start is ignored there too
                    if (r_done) begin
                        r_busy <= 1'b0;
                    end else if (i_start) begin
                        r_num_ch   <= i_cfg_num_ch;
                        r_map_len  <= i_cfg_map_len;
                        r_fraction <= i_cfg_fraction;
                        r_ch       <= '0;
                        r_addr     <= i_cfg_base;
                        r_busy     <= 1'b1;
                        if (i_cfg_num_ch == '0 || i_cfg_map_len == '0) begin
                            r_state <= StFin;
                        end else begin
                            r_state <= StPrime;
                        end
                    end
                end
                StPrime: begin
                    r_idx     <= '0;
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= r_addr;
                    r_addr    <= r_addr + ADDR_W'(1);
                    r_state   <= StStream;
                end
                StStream: begin
                    if (r_idx == r_map_len - LEN_W'(1)) begin
                        r_rd_en     <= 1'b0;
                        r_drain_cnt <= '0;
                        r_state     <= StDrain;
                    end else begin
                        r_idx     <= r_idx + LEN_W'(1);
                        r_rd_addr <= r_addr;
                        r_addr    <= r_addr + ADDR_W'(1);
                    end
                end
                StDrain: begin
                    r_drain_cnt <= r_drain_cnt + DW'(1);
                    if (r_drain_cnt == DRAIN_WR) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ch;
                    end
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_wr_en <= 1'b0;
                        if (r_ch == r_num_ch - CH_W'(1)) begin
                            r_state <= StFin;
                        end else begin
                            r_ch    <= r_ch + CH_W'(1);
                            r_state <= StPrime;
                        end
                    end
                end
                StFin: begin
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Delaying enable and sov by one aligns them with the 1-cycle buffer read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op_en  <= 1'b0;
            r_op_eop <= 1'b0;
        end else begin
            r_op_en  <= r_rd_en;
            r_op_eop <= w_sov;
        end
    end

    vector_ave #(
        .Q    (Q),
        .RELU (RELU)
    ) u_vector_ave (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_din      (i_rd_data),
        .i_din_en   (r_op_en),
        .i_din_eop  (r_op_eop),
        .i_fraction (r_fraction),
        .o_dout     (w_op_dout)
    );

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_addr;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_en ? w_op_dout : '0;

endmodule
